// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and helpers.
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48},
    v: '{active: 480, fp: 10, sync: 2, bp: 33}
  };

  localparam vga_mode_t VGA_800x600 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1, sync: 4, bp: 23}
  };

  localparam vga_mode_t VGA_1024x768 = '{
    h: '{active: 1024, fp: 24, sync: 136, bp: 160},
    v: '{active: 768, fp: 3, sync: 6, bp: 29}
  };

  function automatic int unsigned total(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered decode of the
// position it is about to move to, so the decode lines up with cnt_o.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o,
  output logic             first_o
);

  localparam int unsigned      Total     = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] ActiveEnd = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SyncBeg   = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SyncEnd   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, sync_q, first_q;
  logic             in_sync_d;

  assign wrap_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign in_sync_d = (cnt_d >= SyncBeg) && (cnt_d < SyncEnd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sync_q   <= ~POL;
      first_q  <= 1'b0;
    end else if (en_i) begin
      cnt_q    <= cnt_d;
      active_q <= (cnt_d < ActiveEnd);
      sync_q   <= in_sync_d ? POL : ~POL;
      first_q  <= (cnt_d == '0);
    end
  end

  assign cnt_o    = cnt_q;
  assign active_o = active_q;
  assign sync_o   = sync_q;
  assign first_o  = first_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advancing on a pixel-clock enable,
// with an optional pixel-enable delay line on the sync/blank/marker outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
  parameter int unsigned H_FP     = VGA_640x480.h.fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
  parameter int unsigned H_BP     = VGA_640x480.h.bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
  parameter int unsigned V_FP     = VGA_640x480.v.fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
  parameter int unsigned V_BP     = VGA_640x480.v.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned DELAY    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             sync_n,
  output logic             frame_start,
  output logic             line_start,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_v
);

  localparam vga_timing_t     HTiming  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t     VTiming  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned     H_TOTAL  = total(HTiming);
  localparam int unsigned     V_TOTAL  = total(VTiming);
  localparam longint unsigned CntRange = 64'd1 << CNT_W;
  // Stage vector order: {hsync, vsync, blank_n, frame_start, line_start}
  localparam logic [4:0]      StIdle   = {~HS_POL, ~VS_POL, 3'b000};

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_zero_width
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  if (64'(H_TOTAL) > CntRange || 64'(V_TOTAL) > CntRange) begin : g_cnt_too_narrow
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic run_q;
  logic h_wrap, h_active, h_sync, h_first;
  logic v_active, v_sync, v_first, unused_v_wrap;
  logic h_adv, v_adv;
  logic [4:0] stage0, stage_out;

  // The first pix_en after reset only loads the decode for (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else if (pix_en) begin
      run_q <= 1'b1;
    end
  end

  assign h_adv = pix_en && run_q;
  assign v_adv = h_adv && h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (HS_POL),
    .CNT_W (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pix_en),
    .adv_i   (h_adv),
    .cnt_o   (cnt_h),
    .wrap_o  (h_wrap),
    .active_o(h_active),
    .sync_o  (h_sync),
    .first_o (h_first)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (VS_POL),
    .CNT_W (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pix_en),
    .adv_i   (v_adv),
    .cnt_o   (cnt_v),
    .wrap_o  (unused_v_wrap),
    .active_o(v_active),
    .sync_o  (v_sync),
    .first_o (v_first)
  );

  assign stage0 = {h_sync, v_sync, h_active && v_active, h_first && v_first, h_first};

  if (DELAY == 0) begin : g_no_delay
    assign stage_out = stage0;
  end else begin : g_delay
    logic [4:0] pipe_q [DELAY];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int unsigned i = 0; i < DELAY; i++) begin
          pipe_q[i] <= StIdle;
        end
      end else if (pix_en) begin
        pipe_q[0] <= stage0;
        for (int unsigned i = 1; i < DELAY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign stage_out = pipe_q[DELAY-1];
  end

  assign hsync       = stage_out[4];
  assign vsync       = stage_out[3];
  assign blank_n     = stage_out[2];
  assign frame_start = stage_out[1];
  assign line_start  = stage_out[0];
  assign sync_n      = 1'b1;

endmodule
